// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST sequencer: one memory op per RUN cycle, read compared one cycle later.
// No flow control; stop aborts on the next edge, and a compare still pending at that point is dropped.
module mbist_march_ctrl #(
    parameter int                ADDR_W = 4,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BG     = {DATA_W{1'b0}},
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              tmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]  ERR_MAX  = '1;

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          elem;
    logic                op;
    logic [ADDR_W-1:0]   addr;
    logic                cmp_pend;
    logic [DATA_W-1:0]   cmp_exp;
    logic [ADDR_W-1:0]   cmp_addr;

    logic is_down, two_ops, rd_op, rd_inv, wr_inv, last_op, addr_end, run_end;
    logic start_run, miscmp;

    // E0 and E5 hold a single op; elements 1..4 are (read, write) pairs
    assign is_down   = (elem == 3'd3) || (elem == 3'd4);
    assign two_ops   = (elem != 3'd0) && (elem != 3'd5);
    assign rd_op     = (elem != 3'd0) && !op;
    assign rd_inv    = (elem == 3'd2) || (elem == 3'd4);
    assign wr_inv    = (elem == 3'd1) || (elem == 3'd3);
    assign last_op   = !two_ops || op;
    assign addr_end  = is_down ? (addr == '0) : (addr == ADDR_MAX);
    assign run_end   = last_op && addr_end && (elem == 3'd5);
    assign start_run = ((state == S_IDLE) || (state == S_DONE)) && start && !stop;
    assign miscmp    = cmp_pend && !stop && (mem_rdata != cmp_exp);

    always_comb begin
        state_nxt = state;
        tmode     = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (start_run) state_nxt = S_RUN;
            end
            S_RUN: begin
                tmode    = 1'b1;
                mem_we   = !rd_op;
                mem_re   = rd_op;
                mem_addr = addr;
                if (!rd_op) mem_wdata = wr_inv ? ~BG : BG;
                if (stop)         state_nxt = S_IDLE;
                else if (run_end) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                tmode     = 1'b1;
                state_nxt = stop ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (stop)           state_nxt = S_IDLE;
                else if (start_run) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            elem      <= 3'd0;
            op        <= 1'b0;
            addr      <= '0;
            cmp_pend  <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            if (start_run) begin
                elem      <= 3'd0;
                op        <= 1'b0;
                addr      <= '0;
                cmp_pend  <= 1'b0;
                fail      <= 1'b0;
                fail_addr <= '0;
                err_count <= '0;
            end else begin
                if ((state == S_RUN) && !stop) begin
                    cmp_pend <= rd_op;
                    cmp_exp  <= rd_inv ? ~BG : BG;
                    cmp_addr <= addr;
                    if (!last_op) begin
                        op <= 1'b1;
                    end else begin
                        op <= 1'b0;
                        if (addr_end) begin
                            // next element's start address: E3/E4 walk down from the top
                            elem <= elem + 3'd1;
                            addr <= ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
                        end else begin
                            addr <= is_down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
                        end
                    end
                end else begin
                    cmp_pend <= 1'b0;
                end
                if (miscmp) begin
                    fail <= 1'b1;
                    if (!fail) fail_addr <= cmp_addr;
                    if (err_count != ERR_MAX) err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 4, memory address width; depth D = 2^ADDR_W.
REQ-002 SHALL provide parameter DATA_W, default 8, memory word width.
REQ-003 SHALL provide parameter BG, default {DATA_W{1'b0}}, data background: "w0" writes BG, "w1" writes ~BG.
REQ-004 SHALL provide parameter CNT_W, default 8, error counter width.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  begin test; sampled in IDLE or DONE.
REQ-008 stop  input  1  abort; sampled in every state.
REQ-009 tmode  output  1  test mode active; high in RUN and FLUSH.
REQ-010 mem_addr  output  ADDR_W  memory address for the current operation.
REQ-011 mem_wdata  output  DATA_W  write data.
REQ-012 mem_we  output  1  write strobe, one cycle per write op.
REQ-013 mem_re  output  1  read strobe, one cycle per read op.
REQ-014 mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after mem_re.
REQ-015 done  output  1  test completed without abort; held high in DONE.
REQ-016 fail  output  1  sticky, at least one miscompare this run.
REQ-017 fail_addr  output  ADDR_W  address of the first miscompare.
REQ-018 err_count  output  CNT_W  number of miscompares, saturating at 2^CNT_W-1.

Function
REQ-019 FSM states SHALL be IDLE, RUN, FLUSH, DONE.
REQ-020 IDLE: start=1 and stop=0 -> RUN; clear fail, fail_addr, err_count, element index and address counter on the same edge.
REQ-021 Algorithm SHALL be March C-, one operation per RUN cycle:
  - E0 up (w0)
  - E1 up (r0,w1)
  - E2 up (r1,w0)
  - E3 down (r0,w1)
  - E4 down (r1,w0)
  - E5 up (r0)
  Total 10*D operations.
REQ-022 Up elements SHALL walk address 0..D-1; down elements SHALL walk D-1..0.
REQ-023 Within an element, all ops for one address SHALL complete before the address steps.
REQ-024 Address wrap at the element end SHALL load the next element's start address with no idle cycle.
REQ-025 Exactly one of mem_we/mem_re SHALL be high in each RUN cycle; both SHALL be low in every other state.
REQ-026 Each read SHALL register its expected value (BG or ~BG) and address; compare mem_rdata against them on the following cycle.
REQ-027 On a miscompare:
  - set fail
  - load fail_addr only if fail was 0
  - increment err_count unless saturated
REQ-028 After the last E5 read, the FSM SHALL go to FLUSH for 1 cycle to compare that read, then go to DONE.
REQ-029 DONE: done=1, tmode=0, and results held.
REQ-030 In DONE, start=1 -> RUN and the results are cleared, as in REQ-020.
REQ-031 stop=1 in RUN or FLUSH SHALL go to IDLE next edge with no further memory strobes.
REQ-032 On a stop, a pending compare SHALL be discarded, done SHALL stay 0, and fail/fail_addr/err_count SHALL hold their values.
REQ-033 stop=1 in DONE SHALL go to IDLE and clear done.
REQ-034 stop and start both 1 SHALL mean stop wins.
REQ-035 A miscompare in the same cycle as stop SHALL NOT be recorded.

Reset
REQ-036 rst=1 SHALL force IDLE at the next edge regardless of state, including mid-run.
REQ-037 At reset, tmode, mem_we, mem_re, done, fail SHALL be 0.
REQ-038 At reset, mem_addr, mem_wdata, fail_addr, err_count SHALL be 0.
REQ-039 rst SHALL override start and stop.

Verification
REQ-040 ADDR_W=2, DATA_W=8, fault-free memory, start pulse at edge 0 -> tmode high in cycles 1..41, 40 strobes (E0 writes 0x00 to addr 0,1,2,3), FLUSH in cycle 41, done=1 from cycle 42, fail=0, err_count=0.
REQ-041 Same setup with bit0 of addr 2 stuck at 1 -> fail=1, fail_addr=2, err_count=3 (E1, E3, E5 r0 reads), done=1.
REQ-042 stop asserted in cycle 10 -> IDLE at cycle 11, no strobes from cycle 11, done=0; a restart gives a full clean run.
REQ-043 rst asserted mid-E3 -> all outputs 0 next cycle; subsequent start runs the full 40 ops.
REQ-044 CNT_W=1 with multiple faulty addresses -> err_count saturates at 1, fail_addr = first failing address.
REQ-045 start and stop high together in IDLE -> stays IDLE; start during DONE -> results cleared and a new run begins.
